// File: rtl/flash_burst_reader.sv
// flash_burst_reader
// Reads a burst of consecutive words from an Avalon-MM flash slave, one read
// outstanding at a time, and streams each returned word out with its position
// inside the burst. A read that never returns data is abandoned after TIMEOUT
// cycles, and the burst then ends with the sticky error flag raised.

module flash_burst_reader #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,

    // burst request
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,

    // status
    output logic              busy,
    output logic              finish,
    output logic              error,

    // Avalon-MM read master
    output logic              avm_read,
    output logic [ADDR_W-1:0] avm_address,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,

    // delivered words
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_index
);

    // The timeout counter only has to reach TIMEOUT-1, the value it holds
    // during the last permitted wait cycle.
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  index_q;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              last_word;
    logic              tmo_expired;

    // The word being waited on is the last one once the index reaches
    // count-1; a burst only starts with count >= 1, so this never underflows
    // while it matters.
    assign last_word   = (index_q == (count_q - CNT_W'(1)));
    assign tmo_expired = (tmo_cnt == TMO_LAST);

    // Single-register controller: every output is a flop, updated together
    // with the state so outputs always reflect the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count_q     <= '0;
            index_q     <= '0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            error       <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
        end else begin
            out_valid <= 1'b0;
            finish    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        error   <= 1'b0;
                        index_q <= '0;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        if (word_count != '0) begin
                            count_q     <= word_count;
                            avm_address <= start_addr;
                            avm_read    <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            finish <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                ISSUE: begin
                    // address and read stay put until the slave stops stalling
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    // returned data wins over a timeout expiring in the same cycle
                    if (avm_readdatavalid) begin
                        out_data  <= avm_readdata;
                        out_valid <= 1'b1;
                        out_index <= index_q;
                        if (last_word) begin
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            avm_address <= avm_address + ADDR_W'(1);
                            index_q     <= index_q + CNT_W'(1);
                            avm_read    <= 1'b1;
                            state       <= ISSUE;
                        end
                    end else if (tmo_expired) begin
                        error  <= 1'b1;
                        finish <= 1'b1;
                        state  <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
// tb_flash_burst_reader
// Directed bench for flash_burst_reader with a one-cycle-latency Avalon slave
// model and a scoreboard of expected bus addresses and delivered words.

module tb_flash_burst_reader;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [CNT_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              busy;
    logic              finish;
    logic              error;
    logic              avm_read;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_waitrequest = 1'b0;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [CNT_W-1:0]  out_index;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t              exp_out_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    int accept_count, valid_count, finish_count, busy_count, read_cycles, stall_cycles;
    int last_accept_cyc, finish_cyc;
    int stall_left = 0;
    int respond_limit = 1000;
    bit spurious = 1'b0;
    bit poke = 1'b0;
    bit resp_pending = 1'b0;
    bit stalled_prev = 1'b0;
    logic [ADDR_W-1:0] resp_addr = '0;
    logic [ADDR_W-1:0] stall_addr = '0;

    flash_burst_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .word_count       (word_count),
        .busy             (busy),
        .finish           (finish),
        .error            (error),
        .avm_read         (avm_read),
        .avm_address      (avm_address),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_index        (out_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // contents of the modelled flash: each word is derived from its address
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h90 + {9'b0, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Slave model and output monitor, evaluated mid-cycle while DUT outputs
    // are stable; the slave inputs it drives apply to the next rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset_n) begin
            resp_pending      = 1'b0;
            stalled_prev      = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
        end else begin
            if (busy) busy_count++;
            if (finish) begin
                finish_count++;
                finish_cyc = cyc;
            end
            if (out_valid) begin
                valid_count++;
                if (exp_out_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 64'(out_index), 64'hFFFF);
                end else begin
                    e = exp_out_q.pop_front();
                    checkOutput("out_index", 64'(out_index), 64'(e.idx));
                    checkOutput("out_data", 64'(out_data), 64'(e.data));
                end
            end

            avm_waitrequest = 1'b0;
            if (avm_read) begin
                read_cycles++;
                if (stalled_prev)
                    checkOutput("stall_addr_stable", 64'(avm_address), 64'(stall_addr));
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    stall_cycles++;
                    stalled_prev = 1'b1;
                    stall_addr   = avm_address;
                end else begin
                    stalled_prev = 1'b0;
                    accept_count++;
                    if (accept_count > 1)
                        checkOutput("accept_spacing_ok", 64'(cyc - last_accept_cyc >= 2), 64'd1);
                    last_accept_cyc = cyc;
                    if (exp_addr_q.size() == 0)
                        checkOutput("unexpected_accept", 64'(avm_address), 64'hFFFFFFFF);
                    else
                        checkOutput("avm_address", 64'(avm_address), 64'(exp_addr_q.pop_front()));
                end
            end else begin
                if (stalled_prev) checkOutput("read_held_in_stall", 64'd0, 64'd1);
                stalled_prev = 1'b0;
            end

            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'hDEAD_BEEF;
            if (resp_pending) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_word(resp_addr);
                resp_pending      = 1'b0;
            end else if (spurious && (!busy || avm_waitrequest)) begin
                avm_readdatavalid = 1'b1;
            end
            if (avm_read && !avm_waitrequest && accept_count <= respond_limit) begin
                resp_pending = 1'b1;
                resp_addr    = avm_address;
            end
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // Launch a burst and queue what the bus and output should show for it.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [CNT_W-1:0] wc,
                                 input int n_addr, input int n_valid);
        logic [ADDR_W-1:0] a;
        accept_count = 0; valid_count = 0; finish_count = 0;
        busy_count = 0; read_cycles = 0; stall_cycles = 0;
        for (int i = 0; i < n_addr; i++) begin
            a = addr + ADDR_W'(i);
            exp_addr_q.push_back(a);
        end
        for (int i = 0; i < n_valid; i++) begin
            a = addr + ADDR_W'(i);
            exp_out_q.push_back('{idx: CNT_W'(i), data: mem_word(a)});
        end
        start      = 1'b1;
        start_addr = addr;
        word_count = wc;
        nextCycle();
        start      = 1'b0;
        start_addr = ADDR_W'($urandom);
        word_count = CNT_W'($urandom);
    endtask

    task automatic waitBurst(input int budget);
        int n = 0;
        while (finish_count == 0 && n < budget) begin
            if (poke) begin
                start      = 1'($urandom_range(0, 1));
                start_addr = ADDR_W'($urandom);
                word_count = CNT_W'($urandom);
            end
            nextCycle();
            n++;
        end
        start = 1'b0;
        checkOutput("finish_seen", 64'(finish_count), 64'd1);
    endtask

    task automatic endBurst(input int n_acc, input int n_val, input int n_busy, input logic err);
        nextCycle();
        checkOutput("finish_pulses", 64'(finish_count), 64'd1);
        checkOutput("accepts", 64'(accept_count), 64'(n_acc));
        checkOutput("out_valid_pulses", 64'(valid_count), 64'(n_val));
        checkOutput("busy_cycles", 64'(busy_count), 64'(n_busy));
        checkOutput("error_flag", 64'(error), 64'(err));
        checkOutput("busy_after", 64'(busy), 64'd0);
        checkOutput("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        checkOutput("out_q_empty", 64'(exp_out_q.size()), 64'd0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_finish", 64'(finish), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        checkOutput("rst_avm_read", 64'(avm_read), 64'd0);
        checkOutput("rst_avm_address", 64'(avm_address), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_index", 64'(out_index), 64'd0);
    endtask

    initial begin
        int n;
        $display("[TB] reset");
        #1 reset_n = 1'b0;
        #1 checkResetOutputs();
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        nextCycle();

        $display("[TB] basic 4-word burst");
        applyStimulus(23'h10, 8'd4, 4, 4);
        waitBurst(100);
        endBurst(4, 4, 9, 1'b0);

        $display("[TB] 5-cycle stall on the first read, stray readdatavalid");
        spurious   = 1'b1;
        stall_left = 5;
        nextCycle();
        applyStimulus(23'h20, 8'd4, 4, 4);
        waitBurst(100);
        endBurst(4, 4, 14, 1'b0);
        checkOutput("stall_cycles", 64'(stall_cycles), 64'd5);
        checkOutput("read_cycles", 64'(read_cycles), 64'd9);
        spurious = 1'b0;

        $display("[TB] timeout after second read");
        respond_limit = 1;
        applyStimulus(23'h40, 8'd4, 2, 1);
        waitBurst(100);
        endBurst(2, 1, 12, 1'b1);
        checkOutput("timeout_latency", 64'(finish_cyc - last_accept_cyc), 64'(TIMEOUT + 1));
        respond_limit = 1000;
        repeat (3) nextCycle();
        checkOutput("error_sticky", 64'(error), 64'd1);

        $display("[TB] zero-length burst");
        applyStimulus(23'h55, 8'd0, 0, 0);
        checkOutput("zero_busy", 64'(busy), 64'd1);
        checkOutput("zero_finish", 64'(finish), 64'd1);
        checkOutput("zero_error_cleared", 64'(error), 64'd0);
        checkOutput("zero_no_read", 64'(avm_read), 64'd0);
        waitBurst(20);
        endBurst(0, 0, 1, 1'b0);

        $display("[TB] address wrap with start pokes");
        poke = 1'b1;
        applyStimulus(23'h7FFFFF, 8'd2, 2, 2);
        waitBurst(100);
        poke = 1'b0;
        endBurst(2, 2, 5, 1'b0);

        $display("[TB] reset during second word");
        applyStimulus(23'h100, 8'd4, 4, 4);
        n = 0;
        while (accept_count < 2 && n < 50) begin
            nextCycle();
            n++;
        end
        checkOutput("second_accept_seen", 64'(accept_count), 64'd2);
        nextCycle();
        #1 reset_n = 1'b0;
        #1 checkResetOutputs();
        exp_addr_q.delete();
        exp_out_q.delete();
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        finish_count = 0;
        repeat (2) nextCycle();
        checkOutput("no_finish_after_abort", 64'(finish_count), 64'd0);
        checkOutput("idle_after_abort", 64'(busy), 64'd0);
        applyStimulus(23'h200, 8'd3, 3, 3);
        waitBurst(100);
        endBurst(3, 3, 7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard stop in case the sequence above is ever stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
